// File: rtl/rx_4b5b_framer.sv
// rx_4b5b_framer
//   Receive-side 100BASE-FX PCS framer. Hunts the NRZ bit stream for /J/K/ at any bit offset,
//   then slices aligned 5-bit code groups, decodes 4B/5B data codes and emits bytes (low nibble
//   first) or raw nibbles. Ends a frame on /T/R/ or aborts on invalid codes / idle carrier loss.
//
// Parameters
//   DATA_W     8 = byte assembly, 4 = nibble passthrough
//   IDLE_LOSS  consecutive /I/ groups inside a frame that abort it (1..7)
//   ERR_CNT_W  width of the saturating error counter
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous reset, active-high
//   i_bit_en    bit strobe, i_bit sampled only when high
//   i_bit       NRZ line bit, first bit of a code group is its MSB
//   o_data      decoded byte/nibble, holds between o_valid pulses
//   o_valid     1-clk pulse per output word
//   o_sof       with o_valid on the first word of a frame
//   o_eof       1-clk pulse at frame end (good or abort)
//   o_err       1-clk pulse with o_eof on an abnormal end
//   o_in_frame  high from /J/K/ detect until o_eof
//   o_err_cnt   saturating count of o_err pulses
module rx_4b5b_framer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDLE_LOSS = 2,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_bit_en,
    input  logic                 i_bit,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_valid,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_err,
    output logic                 o_in_frame,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {StHunt, StFrame, StEndR} state_e;

    localparam logic [9:0] JkPattern = 10'b11000_10001;
    localparam logic [4:0] CodeT     = 5'b01101;
    localparam logic [4:0] CodeR     = 5'b00111;
    localparam logic [4:0] CodeI     = 5'b11111;
    localparam logic [2:0] IdleLoss  = 3'(IDLE_LOSS);

    // Returns {hit, nibble}; hit is 0 for any non-data code group.
    function automatic logic [4:0] decode_data(input logic [4:0] code);
        logic [4:0] res;
        res = '0;
        case (code)
            5'b11110: res = {1'b1, 4'h0};
            5'b01001: res = {1'b1, 4'h1};
            5'b10100: res = {1'b1, 4'h2};
            5'b10101: res = {1'b1, 4'h3};
            5'b01010: res = {1'b1, 4'h4};
            5'b01011: res = {1'b1, 4'h5};
            5'b01110: res = {1'b1, 4'h6};
            5'b01111: res = {1'b1, 4'h7};
            5'b10010: res = {1'b1, 4'h8};
            5'b10011: res = {1'b1, 4'h9};
            5'b10110: res = {1'b1, 4'hA};
            5'b10111: res = {1'b1, 4'hB};
            5'b11010: res = {1'b1, 4'hC};
            5'b11011: res = {1'b1, 4'hD};
            5'b11100: res = {1'b1, 4'hE};
            5'b11101: res = {1'b1, 4'hF};
            default:  res = '0;
        endcase
        return res;
    endfunction

    state_e                state_q, state_d;
    // Only the 9 most recent bits need storing: the 10-bit window is {sr_q, i_bit}.
    logic [8:0]            sr_q, sr_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [2:0]            idle_q, idle_d;
    logic                  half_q, half_d;
    logic [3:0]            nib_lo_q, nib_lo_d;
    logic                  first_q, first_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sof_q, sof_d;
    logic                  eof_q, eof_d;
    logic                  err_q, err_d;
    logic                  in_frame_q, in_frame_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [9:0]            window;
    logic [4:0]            code;
    logic [4:0]            dec;
    logic                  group_done;
    logic                  abort;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bitcnt_d   = bitcnt_q;
        idle_d     = idle_q;
        half_d     = half_q;
        nib_lo_d   = nib_lo_q;
        first_d    = first_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        in_frame_d = in_frame_q;
        err_cnt_d  = err_cnt_q;
        abort      = 1'b0;
        window     = {sr_q, i_bit};
        code       = window[4:0];
        dec        = decode_data(code);
        group_done = (bitcnt_q == 3'd4);

        if (i_bit_en) begin
            sr_d = window[8:0];
            unique case (state_q)
                StHunt: begin
                    if (window == JkPattern) begin
                        state_d    = StFrame;
                        in_frame_d = 1'b1;
                        bitcnt_d   = 3'd0;
                        idle_d     = 3'd0;
                        half_d     = 1'b0;
                        first_d    = 1'b1;
                    end
                end
                StFrame: begin
                    bitcnt_d = group_done ? 3'd0 : bitcnt_q + 3'd1;
                    if (group_done) begin
                        if (dec[4]) begin
                            idle_d = 3'd0;
                            if (DATA_W == 4 || half_q) begin
                                valid_d = 1'b1;
                                sof_d   = first_q;
                                first_d = 1'b0;
                                half_d  = 1'b0;
                                data_d  = (DATA_W == 8) ? DATA_W'({dec[3:0], nib_lo_q})
                                                        : DATA_W'(dec[3:0]);
                            end else begin
                                nib_lo_d = dec[3:0];
                                half_d   = 1'b1;
                            end
                        end else if (code == CodeT) begin
                            state_d = StEndR;
                            idle_d  = 3'd0;
                        end else if (code == CodeI) begin
                            idle_d = idle_q + 3'd1;
                            if (idle_q + 3'd1 == IdleLoss) begin
                                abort = 1'b1;
                            end
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                StEndR: begin
                    bitcnt_d = group_done ? 3'd0 : bitcnt_q + 3'd1;
                    if (group_done) begin
                        if (code == CodeR) begin
                            state_d    = StHunt;
                            in_frame_d = 1'b0;
                            eof_d      = 1'b1;
                            // A dangling low nibble means the frame was cut short.
                            err_d      = half_q;
                            half_d     = 1'b0;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase

            if (abort) begin
                state_d    = StHunt;
                in_frame_d = 1'b0;
                eof_d      = 1'b1;
                err_d      = 1'b1;
                half_d     = 1'b0;
            end
        end

        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StHunt;
            sr_q       <= '1;
            bitcnt_q   <= '0;
            idle_q     <= '0;
            half_q     <= 1'b0;
            nib_lo_q   <= '0;
            first_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            in_frame_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bitcnt_q   <= bitcnt_d;
            idle_q     <= idle_d;
            half_q     <= half_d;
            nib_lo_q   <= nib_lo_d;
            first_q    <= first_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            in_frame_q <= in_frame_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_sof      = sof_q;
    assign o_eof      = eof_q;
    assign o_err      = err_q;
    assign o_in_frame = in_frame_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rx_4b5b_framer.sv
// tb_rx_4b5b_framer
//   Drives three framer instances (byte mode, nibble mode, byte mode with a 2-bit error counter)
//   from one bit stream and compares every output every clock against a frame-level model.
module tb_rx_4b5b_framer;

    localparam int IdleLossTb = 2;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic rst    = 1'b1;
    logic bit_en = 1'b0;
    logic bit_i  = 1'b0;

    logic [7:0]  a_data;
    logic        a_valid, a_sof, a_eof, a_err, a_inf;
    logic [15:0] a_cnt;
    logic [3:0]  b_data;
    logic        b_valid, b_sof, b_eof, b_err, b_inf;
    logic [15:0] b_cnt;
    logic [7:0]  c_data;
    logic        c_valid, c_sof, c_eof, c_err, c_inf;
    logic [1:0]  c_cnt;

    rx_4b5b_framer #(.DATA_W(8), .IDLE_LOSS(IdleLossTb), .ERR_CNT_W(16)) dut_a (
        .i_clk(i_clk), .i_rst(rst), .i_bit_en(bit_en), .i_bit(bit_i),
        .o_data(a_data), .o_valid(a_valid), .o_sof(a_sof), .o_eof(a_eof), .o_err(a_err),
        .o_in_frame(a_inf), .o_err_cnt(a_cnt)
    );

    rx_4b5b_framer #(.DATA_W(4), .IDLE_LOSS(IdleLossTb), .ERR_CNT_W(16)) dut_b (
        .i_clk(i_clk), .i_rst(rst), .i_bit_en(bit_en), .i_bit(bit_i),
        .o_data(b_data), .o_valid(b_valid), .o_sof(b_sof), .o_eof(b_eof), .o_err(b_err),
        .o_in_frame(b_inf), .o_err_cnt(b_cnt)
    );

    rx_4b5b_framer #(.DATA_W(8), .IDLE_LOSS(IdleLossTb), .ERR_CNT_W(2)) dut_c (
        .i_clk(i_clk), .i_rst(rst), .i_bit_en(bit_en), .i_bit(bit_i),
        .o_data(c_data), .o_valid(c_valid), .o_sof(c_sof), .o_eof(c_eof), .o_err(c_err),
        .o_in_frame(c_inf), .o_err_cnt(c_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [4:0] codes[16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                              5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                              5'b11010, 5'b11011, 5'b11100, 5'b11101};
    int jk_pat[10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    // ---------------- reference model ----------------
    int dw[3]   = '{8, 4, 8};
    int cmax[3] = '{65535, 65535, 3};
    int hist[$];
    int grp[$];
    int nibs[$];
    bit m_in, m_expr;
    int m_idles;
    int e_data[3], e_cnt[3];
    bit e_valid[3], e_sof[3], e_eof[3], e_err[3], e_inf[3], started[3];

    // Observed-output tallies used by the table checks.
    int wv[3], ws[3], wf[3], we[3], lastd[3];
    int gap = 0;

    function automatic int dec(input int c);
        for (int i = 0; i < 16; i++) if (int'(codes[i]) == c) return i;
        return -1;
    endfunction

    function automatic bit hist_is_jk();
        if (hist.size() != 10) return 1'b0;
        for (int i = 0; i < 10; i++) if (hist[i] != jk_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 3; k++) begin
            e_valid[k] = 0; e_sof[k] = 0; e_eof[k] = 0; e_err[k] = 0;
        end
    endtask

    task automatic m_reset();
        hist.delete(); grp.delete(); nibs.delete();
        repeat (10) hist.push_back(1);
        m_in = 0; m_expr = 0; m_idles = 0;
        m_clear();
        for (int k = 0; k < 3; k++) begin
            e_data[k] = 0; e_cnt[k] = 0; e_inf[k] = 0; started[k] = 0;
        end
    endtask

    task automatic m_end(input bit abrt);
        m_in = 0; m_expr = 0;
        for (int k = 0; k < 3; k++) begin
            e_eof[k] = 1; e_inf[k] = 0;
            e_err[k] = abrt || (dw[k] == 8 && (nibs.size() % 2) == 1);
            if (e_err[k] && e_cnt[k] < cmax[k]) e_cnt[k]++;
        end
    endtask

    task automatic m_emit(input int k, input int val);
        e_valid[k] = 1; e_data[k] = val; e_sof[k] = !started[k]; started[k] = 1;
    endtask

    task automatic m_step(input int b);
        int code, nib, n;
        m_clear();
        hist.push_back(b);
        if (hist.size() > 10) void'(hist.pop_front());
        if (!m_in) begin
            if (hist_is_jk()) begin
                m_in = 1; m_expr = 0; m_idles = 0; grp.delete(); nibs.delete();
                for (int k = 0; k < 3; k++) begin started[k] = 0; e_inf[k] = 1; end
            end
            return;
        end
        grp.push_back(b);
        if (grp.size() < 5) return;
        code = 0;
        foreach (grp[i]) code = code * 2 + grp[i];
        grp.delete();
        if (m_expr) begin
            m_end(code != 7);
            return;
        end
        nib = dec(code);
        if (nib >= 0) begin
            m_idles = 0;
            nibs.push_back(nib);
            n = nibs.size();
            for (int k = 0; k < 3; k++) begin
                if (dw[k] == 4) m_emit(k, nib);
                else if (n % 2 == 0) m_emit(k, nibs[n-1] * 16 + nibs[n-2]);
            end
        end else if (code == 13) begin
            m_expr = 1; m_idles = 0;
        end else if (code == 31) begin
            m_idles++;
            if (m_idles >= IdleLossTb) m_end(1);
        end else begin
            m_end(1);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        int ad[3], av[3], as[3], af[3], ae[3], ai[3], ac[3];
        ad = '{int'(a_data), int'(b_data), int'(c_data)};
        av = '{int'(a_valid), int'(b_valid), int'(c_valid)};
        as = '{int'(a_sof), int'(b_sof), int'(c_sof)};
        af = '{int'(a_eof), int'(b_eof), int'(c_eof)};
        ae = '{int'(a_err), int'(b_err), int'(c_err)};
        ai = '{int'(a_inf), int'(b_inf), int'(c_inf)};
        ac = '{int'(a_cnt), int'(b_cnt), int'(c_cnt)};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d.data", k), ad[k], e_data[k]);
            chk($sformatf("dut%0d.valid", k), av[k], int'(e_valid[k]));
            chk($sformatf("dut%0d.sof", k), as[k], int'(e_sof[k]));
            chk($sformatf("dut%0d.eof", k), af[k], int'(e_eof[k]));
            chk($sformatf("dut%0d.err", k), ae[k], int'(e_err[k]));
            chk($sformatf("dut%0d.in_frame", k), ai[k], int'(e_inf[k]));
            chk($sformatf("dut%0d.err_cnt", k), ac[k], e_cnt[k]);
            if (av[k] != 0) begin wv[k]++; lastd[k] = ad[k]; end
            if (as[k] != 0) ws[k]++;
            if (af[k] != 0) wf[k]++;
            if (ae[k] != 0) we[k]++;
        end
    endtask

    task automatic clear_tally();
        for (int k = 0; k < 3; k++) begin wv[k] = 0; ws[k] = 0; wf[k] = 0; we[k] = 0; end
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input bit en, input bit b, input bit r);
        bit_en = en; bit_i = b; rst = r;
        if (r) m_reset();
        else if (en) m_step(int'(b));
        else m_clear();
        @(posedge i_clk);
        #1;
        compare_all();
    endtask

    task automatic send_bit(input bit b);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic send_code(input logic [4:0] c);
        for (int i = 4; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic send_nib(input logic [3:0] n);
        send_code(codes[n]);
    endtask

    // tail: 0 = /T/R/, 1 = code 00000, 2 = /I/I/, 3 = /T/ then /I/
    typedef struct {
        int          idle;
        int          pre;
        logic [7:0]  pre_bits;
        int          n_nib;
        logic [63:0] nibs;
        int          idle_at;
        int          tail;
        int          gap;
        int          e8_w;
        int          e8_e;
        int          e4_w;
        int          e4_e;
    } vec_t;

    task automatic send_frame(input vec_t v);
        gap = v.gap;
        for (int i = 0; i < v.idle; i++) send_bit(1'b1);
        for (int i = v.pre - 1; i >= 0; i--) send_bit(v.pre_bits[i]);
        send_code(5'b11000);
        send_code(5'b10001);
        for (int i = 0; i < v.n_nib; i++) begin
            if (i == v.idle_at) send_code(5'b11111);
            send_nib(v.nibs[4*i +: 4]);
        end
        case (v.tail)
            0:       begin send_code(5'b01101); send_code(5'b00111); end
            1:       send_code(5'b00000);
            2:       begin send_code(5'b11111); send_code(5'b11111); end
            default: begin send_code(5'b01101); send_code(5'b11111); end
        endcase
        for (int i = 0; i < 5; i++) send_bit(1'b1);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        //          idle pre bits  n  nibbles              at  tl gp e8w e8e e4w e4e
        vecs[0] = '{20, 0, 8'h00, 10, 64'h55_5555_5555,    -1, 0, 0, 5, 0, 10, 0};
        vecs[1] = '{10, 3, 8'h02, 4,  64'hD555,            -1, 0, 0, 2, 0, 4,  0};
        vecs[2] = '{6,  0, 8'h00, 4,  64'h5D55,            -1, 1, 0, 2, 1, 4,  1};
        vecs[3] = '{6,  0, 8'h00, 3,  64'h321,             -1, 0, 0, 1, 1, 3,  0};
        vecs[4] = '{6,  0, 8'h00, 4,  64'hDCBA,            2,  0, 0, 2, 0, 4,  0};
        vecs[5] = '{6,  0, 8'h00, 2,  64'h55,              -1, 2, 0, 1, 1, 2,  1};
        vecs[6] = '{4,  2, 8'h01, 8,  64'h7654_3210,       -1, 0, 3, 4, 0, 8,  0};
        vecs[7] = '{6,  0, 8'h00, 2,  64'hE9,              -1, 3, 1, 1, 1, 2,  1};

        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("reset valid", int'(a_valid), 0);
        chk("reset in_frame", int'(a_inf), 0);
        chk("reset data", int'(a_data), 0);
        chk("reset err_cnt", int'(a_cnt), 0);

        for (int r = 0; r < 8; r++) begin
            clear_tally();
            send_frame(vecs[r]);
            chk($sformatf("row%0d bytes", r), wv[0], vecs[r].e8_w);
            chk($sformatf("row%0d byte err", r), we[0], vecs[r].e8_e);
            chk($sformatf("row%0d byte eof", r), wf[0], 1);
            chk($sformatf("row%0d byte sof", r), ws[0], (vecs[r].e8_w > 0) ? 1 : 0);
            chk($sformatf("row%0d nibbles", r), wv[1], vecs[r].e4_w);
            chk($sformatf("row%0d nibble err", r), we[1], vecs[r].e4_e);
            chk($sformatf("row%0d nibble eof", r), wf[1], 1);
        end

        for (int r = 0; r < 25; r++) begin
            rv.idle     = $urandom_range(0, 12);
            rv.pre      = $urandom_range(0, 7);
            rv.pre_bits = 8'($urandom);
            rv.n_nib    = $urandom_range(0, 16);
            rv.nibs     = {$urandom, $urandom};
            rv.idle_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            rv.tail     = $urandom_range(0, 3);
            rv.gap      = $urandom_range(0, 2);
            send_frame(rv);
            if (r % 5 == 4) begin
                gap = 0;
                for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
                for (int i = 0; i < 15; i++) send_bit(1'b1);
            end
        end

        // Five aborted frames: 16-bit counter reads 5, 2-bit counter saturates at 3.
        cyc(1'b0, 1'b0, 1'b1);
        gap = 0;
        for (int i = 0; i < 5; i++) begin
            send_code(5'b11000); send_code(5'b10001);
            send_nib(4'h5); send_nib(4'h5);
            send_code(5'b00000);
            for (int j = 0; j < 3; j++) send_bit(1'b1);
        end
        chk("err_cnt after 5 aborts", int'(a_cnt), 5);
        chk("2-bit err_cnt saturated", int'(c_cnt), 3);

        // Sparse strobes, reset mid-byte, then a clean frame.
        gap = 3;
        send_code(5'b11000); send_code(5'b10001);
        send_nib(4'h5);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("mid reset in_frame", int'(a_inf), 0);
        chk("mid reset data", int'(a_data), 0);
        chk("mid reset err_cnt", int'(a_cnt), 0);
        chk("mid reset cnt2", int'(c_cnt), 0);
        chk("mid reset eof", int'(a_eof), 0);
        clear_tally();
        send_frame('{2, 0, 8'h00, 2, 64'hD5, -1, 0, 3, 1, 0, 2, 0});
        chk("post reset bytes", wv[0], 1);
        chk("post reset byte", lastd[0], 8'hD5);
        chk("post reset sof", ws[0], 1);
        chk("post reset eof", wf[0], 1);
        chk("post reset err", we[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
